// File: rtl/ramb4_s4_fifo_ctrl_pkg.sv
// Shared constants and types for the RAMB4_S4 FIFO controller.
package ramb4_fifo_pkg;

    // Default geometry of the 1024x4 block RAM behind the controller
    localparam int FIFO_ADDR_W = 10;
    localparam int FIFO_DATA_W = 4;

    // Which side owns the single RAM port in a given cycle
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;

endpackage

// File: rtl/ramb4_s4_fifo_ctrl_if.sv
// Push/pop bus plus the RAM pin bundle of the FIFO controller.
// slave  = controller side, master = surrounding logic and RAM side.
interface ramb4_s4_fifo_ctrl_if #(
    parameter int ADDR_W = ramb4_fifo_pkg::FIFO_ADDR_W,
    parameter int DATA_W = ramb4_fifo_pkg::FIFO_DATA_W
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              afull;
    logic              aempty;
    logic              ovf;
    logic              udf;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic              ram_we;
    logic              ram_en;
    logic [DATA_W-1:0] ram_do;

    modport slave (
        input  wr_valid, wr_data, rd_req, ram_do,
        output wr_ready, rd_ack, rd_valid, rd_data,
               full, empty, afull, aempty, ovf, udf,
               ram_addr, ram_di, ram_we, ram_en
    );

    modport master (
        output wr_valid, wr_data, rd_req, ram_do,
        input  wr_ready, rd_ack, rd_valid, rd_data,
               full, empty, afull, aempty, ovf, udf,
               ram_addr, ram_di, ram_we, ram_en
    );
endinterface

// File: rtl/ramb4_s4_fifo_ctrl_arb.sv
// Single-port arbiter: picks write or read for the RAM each cycle.
// On a conflict the favoured side alternates so neither side starves.
module ramb4_fifo_arb
    import ramb4_fifo_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_wr_elig,
    input  logic   i_rd_elig,
    output grant_t o_grant
);
    logic r_prio;
    logic w_prio_next;

    // Grant decision; priority flips only when both sides compete
    always_comb begin
        o_grant     = GNT_NONE;
        w_prio_next = r_prio;
        if (i_wr_elig && i_rd_elig) begin
            o_grant     = r_prio ? GNT_RD : GNT_WR;
            w_prio_next = ~r_prio;
        end else if (i_wr_elig) begin
            o_grant = GNT_WR;
        end else if (i_rd_elig) begin
            o_grant = GNT_RD;
        end
    end

    // Priority register, write favoured after reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio <= 1'b0;
        end else begin
            r_prio <= w_prio_next;
        end
    end
endmodule

// File: rtl/ramb4_s4_fifo_ctrl.sv
// FIFO controller in front of a 1024x4 single-port block RAM.
// Optional sticky overflow/underflow flags: define RAMB4_FIFO_ERR_FLAGS_EN.
module ramb4_s4_fifo_ctrl
    import ramb4_fifo_pkg::*;
#(
    parameter int ADDR_W        = FIFO_ADDR_W,
    parameter int DATA_W        = FIFO_DATA_W,
    parameter int AFULL_THRESH  = 1000,
    parameter int AEMPTY_THRESH = 16
)(
    input logic                 i_clk,
    input logic                 i_rst,
    ramb4_s4_fifo_ctrl_if.slave fifo_bus
);
    localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_THRESH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_rd_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_elig;
    logic              w_rd_elig;
    grant_t            w_grant;

    assign w_full  = (r_count == DEPTH);
    assign w_empty = (r_count == '0);

    // Reset gating keeps the RAM port quiet while reset is held
    assign w_wr_elig = fifo_bus.wr_valid & ~w_full  & ~i_rst;
    assign w_rd_elig = fifo_bus.rd_req   & ~w_empty & ~i_rst;

    ramb4_fifo_arb u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_elig (w_wr_elig),
        .i_rd_elig (w_rd_elig),
        .o_grant   (w_grant)
    );

    assign fifo_bus.wr_ready = (w_grant == GNT_WR);
    assign fifo_bus.rd_ack   = (w_grant == GNT_RD);
    assign fifo_bus.full     = w_full;
    assign fifo_bus.empty    = w_empty;
    assign fifo_bus.afull    = (r_count >= AFULL_LVL);
    assign fifo_bus.aempty   = (r_count <= AEMPTY_LVL);
    assign fifo_bus.rd_valid = r_rd_valid;
    assign fifo_bus.rd_data  = fifo_bus.ram_do;

    // RAM pin drive follows the grant; idle parks the address on rd_ptr
    always_comb begin
        fifo_bus.ram_en   = 1'b0;
        fifo_bus.ram_we   = 1'b0;
        fifo_bus.ram_addr = r_rd_ptr;
        fifo_bus.ram_di   = '0;
        case (w_grant)
            GNT_WR: begin
                fifo_bus.ram_en   = 1'b1;
                fifo_bus.ram_we   = 1'b1;
                fifo_bus.ram_addr = r_wr_ptr;
                fifo_bus.ram_di   = fifo_bus.wr_data;
            end
            GNT_RD: begin
                fifo_bus.ram_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointers, occupancy and read-valid pipeline stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= (w_grant == GNT_RD);
            case (w_grant)
                GNT_WR: begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    r_count  <= r_count + (ADDR_W+1)'(1);
                end
                GNT_RD: begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                    r_count  <= r_count - (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef RAMB4_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // Sticky capture of pushes into a full FIFO and pops from an empty one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (fifo_bus.wr_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            if (fifo_bus.rd_req && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign fifo_bus.ovf = r_ovf;
    assign fifo_bus.udf = r_udf;
`else
    assign fifo_bus.ovf = 1'b0;
    assign fifo_bus.udf = 1'b0;
`endif

endmodule
